// File: rtl/mig_req_sched.sv
// Migration request scheduler: filters hot cache-line addresses down to unique pages,
// queues them, and issues ID-tagged migration requests bounded by an in-flight table.
module mig_req_sched #(
  parameter int ADDR_SIZE       = 28,
  parameter int PAGE_SHIFT      = 6,
  parameter int FIFO_DEPTH      = 8,
  parameter int FIFO_DEPTH_BITS = 3,
  parameter int MAX_INFLIGHT    = 4,
  parameter int ID_BITS         = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          enable,
  input  logic                          mig_addr_en,
  input  logic [ADDR_SIZE-1:0]          mig_addr,
  output logic                          mig_addr_ready,
  output logic                          mig_req_valid,
  output logic [ADDR_SIZE-PAGE_SHIFT-1:0] mig_req_page,
  output logic [ID_BITS-1:0]            mig_req_id,
  input  logic                          mig_req_ready,
  input  logic                          mig_done_en,
  input  logic [ID_BITS-1:0]            mig_done_id,
  output logic [ID_BITS:0]              inflight_cnt,
  output logic [31:0]                   issued_cnt,
  output logic [31:0]                   dropped_cnt,
  output logic                          done_err
);

  localparam int PAGE_SIZE = ADDR_SIZE - PAGE_SHIFT;
  localparam logic [FIFO_DEPTH_BITS:0] FIFO_FULL_CNT = (FIFO_DEPTH_BITS+1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_REQ} state_e;

  state_e                     state_q, state_d;
  logic [PAGE_SIZE-1:0]       fifo_mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_BITS:0]   count_q, count_d;
  logic [PAGE_SIZE-1:0]       req_page_q, req_page_d;
  logic [ID_BITS-1:0]         req_id_q, req_id_d;
  logic [MAX_INFLIGHT-1:0]    busy_q, busy_d;
  logic [PAGE_SIZE-1:0]       busy_page_q [MAX_INFLIGHT];
  logic [31:0]                issued_cnt_q, issued_cnt_d;
  logic [31:0]                dropped_cnt_q, dropped_cnt_d;
  logic                       done_err_q, done_err_d;

  logic [PAGE_SIZE-1:0]       in_page;
  logic                       fifo_full, fifo_empty;
  logic                       accept, dup_hit, push, pop, req_fire;
  logic [FIFO_DEPTH_BITS-1:0] slot_off;
  logic [MAX_INFLIGHT-1:0]    free_mask;
  logic                       any_free;
  logic [ID_BITS-1:0]         free_id;
  logic [ID_BITS:0]           inflight_sum;

  assign in_page        = mig_addr[ADDR_SIZE-1:PAGE_SHIFT];
  assign fifo_full      = (count_q == FIFO_FULL_CNT);
  assign fifo_empty     = (count_q == '0);
  assign mig_addr_ready = !fifo_full;
  assign accept         = mig_addr_en && mig_addr_ready;
  assign push           = accept && !dup_hit;
  assign req_fire       = (state_q == S_REQ) && mig_req_ready;

  // Dedup looks only at start-of-cycle state, so a head popped this cycle still matches.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    dup_hit  = 1'b0;
    slot_off = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot_off = FIFO_DEPTH_BITS'(i) - rd_ptr_q;
      if (({1'b0, slot_off} < count_q) && (fifo_mem_q[i] == in_page)) dup_hit = 1'b1;
    end
    if ((state_q == S_REQ) && (req_page_q == in_page)) dup_hit = 1'b1;
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      if (busy_q[i] && (busy_page_q[i] == in_page)) dup_hit = 1'b1;
    end
  end

  // The held ID is reserved while its request waits for the engine.
  always_comb begin
    free_mask = ~busy_q;
    if (state_q == S_REQ) free_mask[req_id_q] = 1'b0;
    any_free = |free_mask;
    free_id  = '0;
    for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
      if (free_mask[i]) free_id = ID_BITS'(i);
    end
  end

  assign pop = (state_q == S_IDLE) && enable && !fifo_empty && any_free;

  always_comb begin
    state_d       = state_q;
    req_page_d    = req_page_q;
    req_id_d      = req_id_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    busy_d        = busy_q;
    issued_cnt_d  = issued_cnt_q;
    dropped_cnt_d = dropped_cnt_q;
    done_err_d    = done_err_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          req_page_d = fifo_mem_q[rd_ptr_q];
          req_id_d   = free_id;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (mig_req_ready) begin
          busy_d[req_id_q] = 1'b1;
          if (issued_cnt_q != '1) issued_cnt_d = issued_cnt_q + 32'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (accept && dup_hit && (dropped_cnt_q != '1)) dropped_cnt_d = dropped_cnt_q + 32'd1;

    // The request being handed over is never busy yet, so a completion cannot collide with it.
    if (mig_done_en) begin
      if (busy_q[mig_done_id]) busy_d[mig_done_id] = 1'b0;
      else                     done_err_d          = 1'b1;
    end
  end

  always_comb begin
    inflight_sum = '0;
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      inflight_sum = inflight_sum + {{ID_BITS{1'b0}}, busy_q[i]};
    end
    if (state_q == S_REQ) inflight_sum = inflight_sum + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      state_q       <= S_IDLE;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      req_page_q    <= '0;
      req_id_q      <= '0;
      busy_q        <= '0;
      issued_cnt_q  <= '0;
      dropped_cnt_q <= '0;
      done_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      req_page_q    <= req_page_d;
      req_id_q      <= req_id_d;
      busy_q        <= busy_d;
      issued_cnt_q  <= issued_cnt_d;
      dropped_cnt_q <= dropped_cnt_d;
      done_err_q    <= done_err_d;
    end
  end

  // NOTE: storage arrays are not reset; count_q and busy_q qualify every read, so contents are don't-care.
  always_ff @(posedge clk) begin
    if (push)     fifo_mem_q[wr_ptr_q]  <= in_page;
    if (req_fire) busy_page_q[req_id_q] <= req_page_q;
  end

  assign mig_req_valid = (state_q == S_REQ);
  assign mig_req_page  = req_page_q;
  assign mig_req_id    = req_id_q;
  assign inflight_cnt  = inflight_sum;
  assign issued_cnt    = issued_cnt_q;
  assign dropped_cnt   = dropped_cnt_q;
  assign done_err      = done_err_q;

endmodule

// File: tb/tb_mig_req_sched.sv
// Bench for mig_req_sched: a table of FIFO-fill/dedup vectors, a page scoreboard fed at
// stimulus time and drained on each request handshake, and hand-written timing sequences.
module tb_mig_req_sched;

  localparam int ADDR_SIZE  = 28;
  localparam int PAGE_SHIFT = 6;
  localparam int PAGE_SIZE  = ADDR_SIZE - PAGE_SHIFT;
  localparam int ID_BITS    = 2;

  logic                 clk;
  logic                 rstn;
  logic                 enable;
  logic                 mig_addr_en;
  logic [ADDR_SIZE-1:0] mig_addr;
  logic                 mig_addr_ready;
  logic                 mig_req_valid;
  logic [PAGE_SIZE-1:0] mig_req_page;
  logic [ID_BITS-1:0]   mig_req_id;
  logic                 mig_req_ready;
  logic                 mig_done_en;
  logic [ID_BITS-1:0]   mig_done_id;
  logic [ID_BITS:0]     inflight_cnt;
  logic [31:0]          issued_cnt;
  logic [31:0]          dropped_cnt;
  logic                 done_err;

  mig_req_sched dut (
    .clk            (clk),
    .rstn           (rstn),
    .enable         (enable),
    .mig_addr_en    (mig_addr_en),
    .mig_addr       (mig_addr),
    .mig_addr_ready (mig_addr_ready),
    .mig_req_valid  (mig_req_valid),
    .mig_req_page   (mig_req_page),
    .mig_req_id     (mig_req_id),
    .mig_req_ready  (mig_req_ready),
    .mig_done_en    (mig_done_en),
    .mig_done_id    (mig_done_id),
    .inflight_cnt   (inflight_cnt),
    .issued_cnt     (issued_cnt),
    .dropped_cnt    (dropped_cnt),
    .done_err       (done_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                   n_tests = 0;
  int                   n_fail  = 0;
  logic [PAGE_SIZE-1:0] sb_q [$];
  logic [PAGE_SIZE-1:0] sb_exp;

  typedef struct {
    logic [ADDR_SIZE-1:0] addr;
    bit                   exp_ready;
    bit                   exp_push;
    logic [31:0]          exp_dropped;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn          = 1'b0;
    enable        = 1'b0;
    mig_addr_en   = 1'b0;
    mig_addr      = '0;
    mig_req_ready = 1'b0;
    mig_done_en   = 1'b0;
    mig_done_id   = '0;
    tick();
    tick();
    sb_q.delete();
    rstn = 1'b1;
    tick();
  endtask

  task automatic send(input logic [ADDR_SIZE-1:0] a, input bit expect_push);
    mig_addr_en = 1'b1;
    mig_addr    = a;
    if (expect_push) sb_q.push_back(a[ADDR_SIZE-1:PAGE_SHIFT]);
    tick();
    mig_addr_en = 1'b0;
  endtask

  task automatic complete(input logic [ID_BITS-1:0] id);
    mig_done_en = 1'b1;
    mig_done_id = id;
    tick();
    mig_done_en = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int n = 0;
    while (!mig_req_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, mig_req_valid, 1);
  endtask

  // Scoreboard drain: a handshake happens at the next edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rstn && mig_req_valid && mig_req_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got page 0x%0h, expected no request", mig_req_page);
      end else begin
        sb_exp = sb_q.pop_front();
        check("sb_page", mig_req_page, sb_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{28'h0000040, 1'b1, 1'b1, 32'd0};
    vecs[1]  = '{28'h000007F, 1'b1, 1'b0, 32'd1};
    vecs[2]  = '{28'h0000080, 1'b1, 1'b1, 32'd1};
    vecs[3]  = '{28'h00000C0, 1'b1, 1'b1, 32'd1};
    vecs[4]  = '{28'h0000100, 1'b1, 1'b1, 32'd1};
    vecs[5]  = '{28'h0000140, 1'b1, 1'b1, 32'd1};
    vecs[6]  = '{28'h0000180, 1'b1, 1'b1, 32'd1};
    vecs[7]  = '{28'h00001C0, 1'b1, 1'b1, 32'd1};
    vecs[8]  = '{28'h0000200, 1'b1, 1'b1, 32'd1};
    vecs[9]  = '{28'h0000240, 1'b0, 1'b0, 32'd1};
    vecs[10] = '{28'h0000240, 1'b0, 1'b0, 32'd1};

    // Reset state
    do_reset();
    check("rst_valid",    mig_req_valid,  0);
    check("rst_page",     mig_req_page,   0);
    check("rst_id",       mig_req_id,     0);
    check("rst_issued",   issued_cnt,     0);
    check("rst_dropped",  dropped_cnt,    0);
    check("rst_done_err", done_err,       0);
    check("rst_inflight", inflight_cnt,   0);
    check("rst_ready",    mig_addr_ready, 1);

    // Single request: issue latency T+2
    enable        = 1'b1;
    mig_req_ready = 1'b1;
    send(28'h00001C0, 1'b1);
    check("t1_valid_t1", mig_req_valid, 0);
    tick();
    check("t1_valid_t2", mig_req_valid, 1);
    check("t1_page",     mig_req_page,  32'h7);
    check("t1_id",       mig_req_id,    0);
    tick();
    check("t1_issued",   issued_cnt,    1);
    check("t1_inflight", inflight_cnt,  1);
    check("t1_valid_t3", mig_req_valid, 0);
    complete(2'd0);
    check("t1_inflight_done", inflight_cnt, 0);
    check("t1_done_err",      done_err,     0);

    // Duplicate arriving while its page is popped in the same cycle
    send(28'h0002000, 1'b1);
    send(28'h0002010, 1'b0);
    check("t1b_dropped", dropped_cnt,   1);
    check("t1b_valid",   mig_req_valid, 1);
    check("t1b_id",      mig_req_id,    0);
    tick();
    check("t1b_issued",  issued_cnt,    2);
    complete(2'd0);
    check("t1b_drain",   sb_q.size(),   0);

    // Table: dedup with issue disabled, then fill to full and hold the rejected address
    do_reset();
    mig_req_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      mig_addr_en = 1'b1;
      mig_addr    = vecs[i].addr;
      check($sformatf("t2_ready[%0d]", i), mig_addr_ready, vecs[i].exp_ready);
      if (vecs[i].exp_push) sb_q.push_back(vecs[i].addr[ADDR_SIZE-1:PAGE_SHIFT]);
      tick();
      check($sformatf("t2_dropped[%0d]", i), dropped_cnt, vecs[i].exp_dropped);
    end
    mig_addr_en = 1'b0;
    check("t2_valid_disabled", mig_req_valid, 0);

    // ID exhaustion: IDs 0..3 in order, then nothing issues
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_valid($sformatf("t3_wait[%0d]", i), 10);
      check($sformatf("t3_id[%0d]", i), mig_req_id, i);
      tick();
    end
    tick();
    tick();
    check("t3_valid_exhausted", mig_req_valid,  0);
    check("t3_inflight",        inflight_cnt,   4);
    check("t3_issued",          issued_cnt,     4);
    check("t3_ready",           mig_addr_ready, 1);
    send(28'h0000041, 1'b0);
    check("t3_dropped_busy",    dropped_cnt,    2);
    send(28'h0000240, 1'b1);
    check("t3_dropped_new",     dropped_cnt,    2);

    // Completion of ID 2 makes it allocatable one cycle later
    complete(2'd2);
    check("t3_valid_after_done", mig_req_valid, 0);
    check("t3_inflight_done",    inflight_cnt,  3);
    tick();
    check("t3_reissue_valid",    mig_req_valid, 1);
    check("t3_reissue_id",       mig_req_id,    2);
    tick();
    check("t3_inflight_full",    inflight_cnt,  4);
    check("t3_issued_5",         issued_cnt,    5);
    check("t3_done_err",         done_err,      0);

    // Stall in S_REQ: request held stable, enable drop ignored, duplicate of held page dropped
    do_reset();
    enable = 1'b1;
    send(28'h0001000, 1'b1);
    tick();
    check("t4_valid", mig_req_valid, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        mig_addr_en = 1'b1;
        mig_addr    = 28'h0001025;
      end
      if (i == 2) enable = 1'b0;
      tick();
      mig_addr_en = 1'b0;
      check($sformatf("t4_valid[%0d]", i), mig_req_valid, 1);
      check($sformatf("t4_page[%0d]", i),  mig_req_page,  32'h40);
      check($sformatf("t4_id[%0d]", i),    mig_req_id,    0);
    end
    check("t4_dropped", dropped_cnt, 1);

    // Completion for a free ID is sticky and changes nothing else
    complete(2'd3);
    check("t5_done_err",  done_err,     1);
    check("t5_inflight",  inflight_cnt, 1);
    tick();
    check("t5_done_err_sticky", done_err,      1);
    check("t5_valid_held",      mig_req_valid, 1);

    // Reset mid-S_REQ
    rstn = 1'b0;
    tick();
    sb_q.delete();
    check("t6_valid",    mig_req_valid, 0);
    check("t6_page",     mig_req_page,  0);
    check("t6_id",       mig_req_id,    0);
    check("t6_issued",   issued_cnt,    0);
    check("t6_dropped",  dropped_cnt,   0);
    check("t6_done_err", done_err,      0);
    check("t6_inflight", inflight_cnt,  0);
    rstn = 1'b1;
    tick();
    check("t6_ready",    mig_addr_ready, 1);
    complete(2'd0);
    check("t6_stale_done_err", done_err, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
